// File: rtl/alu32_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : alu32_checker_if
// Description : Bundle of the signals exchanged between the ALU response
//               checker and its environment. It carries the run control
//               pulses, the applied ALU operation with the observed response,
//               and the checker status, counters and first-failure record.
//               The master drives samples and control; the slave is the
//               checker itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu32_checker_if #(
    parameter int CNT_W = 16
);
    // Run control
    logic             start;
    logic             stop;

    // Sample: applied operation plus the ALU's observed response
    logic             in_valid;
    logic [31:0]      in_A;
    logic [31:0]      in_B;
    logic [2:0]       in_Op;
    logic [31:0]      in_R;
    logic             in_Zero;
    logic             in_Overflow;

    // Status and results
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] first_fail_idx;
    logic [2:0]       first_fail_op;
    logic [31:0]      first_fail_exp;

    modport master (
        output start, stop, in_valid, in_A, in_B, in_Op, in_R, in_Zero, in_Overflow,
        input  busy, done, error, pass_cnt, fail_cnt,
               first_fail_idx, first_fail_op, first_fail_exp
    );

    modport slave (
        input  start, stop, in_valid, in_A, in_B, in_Op, in_R, in_Zero, in_Overflow,
        output busy, done, error, pass_cnt, fail_cnt,
               first_fail_idx, first_fail_op, first_fail_exp
    );
endinterface
`default_nettype wire

// File: rtl/alu32_checker.sv
`default_nettype none
// ============================================================================
// Module      : alu32_checker
// Description : Self-checking response monitor for the 32-bit ALU. Each
//               sample (A, B, Op, observed R/Zero/Overflow) is registered in
//               stage 1, compared against a golden model in stage 2, and
//               counted as pass or fail. The first mismatch after start is
//               latched as a sticky record (index, op, expected R).
//               Optional feature macro: ALU32_CHK_OVF_EN - when defined, the
//               Overflow flag is predicted and also compared.
// Ports       : clk            - clock, rising edge
//               reset          - asynchronous active-high reset
//               bus (slave)    - start/stop, sample inputs, busy/done/error,
//                                pass/fail counters, first-failure record
// Revision    : 1.0 - initial release
// ============================================================================
module alu32_checker #(
    parameter int CNT_W = 16
) (
    input  wire logic      clk,
    input  wire logic      reset,
    alu32_checker_if.slave bus
);

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_XOR = 3'b011;
    localparam logic [2:0] c_OP_SUB = 3'b100;
    localparam logic [2:0] c_OP_SRA = 3'b101;
    localparam logic [2:0] c_OP_SLL = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [CNT_W-1:0] r_ff_idx;
    logic [2:0]       r_ff_op;
    logic [31:0]      r_ff_exp;

    // Stage-1 sample registers
    logic             r_s1_vld;
    logic [31:0]      r_s1_a;
    logic [31:0]      r_s1_b;
    logic [2:0]       r_s1_op;
    logic [31:0]      r_s1_r;
    logic             r_s1_z;

    logic             w_capture;
    logic [4:0]       w_sh;
    logic [31:0]      w_exp_r;
    logic             w_exp_z;
    logic             w_match;
    logic [CNT_W-1:0] w_idx;

    // A start pulse restarts the run, so a sample offered alongside it is dropped.
    assign w_capture = (r_state == S_RUN) && bus.in_valid && !bus.start;

    // ------------------------------------------------------------------
    // Golden model
    // ------------------------------------------------------------------
    assign w_sh = r_s1_b[4:0];

    always_comb begin
        w_exp_r = '0;
        case (r_s1_op)
            c_OP_AND: w_exp_r = r_s1_a & r_s1_b;
            c_OP_OR:  w_exp_r = r_s1_a | r_s1_b;
            c_OP_ADD: w_exp_r = r_s1_a + r_s1_b;
            c_OP_XOR: w_exp_r = r_s1_a ^ r_s1_b;
            c_OP_SUB: w_exp_r = r_s1_a - r_s1_b;
            c_OP_SRA: w_exp_r = $unsigned($signed(r_s1_a) >>> w_sh);
            c_OP_SLL: w_exp_r = r_s1_a << w_sh;
            default:  w_exp_r = ~(r_s1_a | r_s1_b);
        endcase
    end

    assign w_exp_z = (w_exp_r == 32'd0);

`ifdef ALU32_CHK_OVF_EN
    logic r_s1_ovf;
    logic w_exp_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_ovf <= 1'b0;
        end else if (w_capture) begin
            r_s1_ovf <= bus.in_Overflow;
        end
    end

    // Signed overflow: ADD with like-signed operands, or SUB with unlike-signed
    // operands, whose result sign differs from A.
    always_comb begin
        w_exp_ovf = 1'b0;
        case (r_s1_op)
            c_OP_ADD: w_exp_ovf = (r_s1_a[31] == r_s1_b[31]) && (w_exp_r[31] != r_s1_a[31]);
            c_OP_SUB: w_exp_ovf = (r_s1_a[31] != r_s1_b[31]) && (w_exp_r[31] != r_s1_a[31]);
            default:  w_exp_ovf = 1'b0;
        endcase
    end

    assign w_match = (w_exp_r == r_s1_r) && (w_exp_z == r_s1_z) && (w_exp_ovf == r_s1_ovf);
`else
    logic w_unused_ovf;
    assign w_unused_ovf = bus.in_Overflow;

    assign w_match = (w_exp_r == r_s1_r) && (w_exp_z == r_s1_z);
`endif

    // Index of the sample being retired, taken from the counters before increment.
    assign w_idx = r_pass_cnt + r_fail_cnt;

    // ------------------------------------------------------------------
    // Control FSM, stage-1 capture and stage-2 scoring
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_ff_idx   <= '0;
            r_ff_op    <= '0;
            r_ff_exp   <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
            r_s1_r     <= '0;
            r_s1_z     <= 1'b0;
        end else begin
            r_s1_vld <= w_capture;
            if (w_capture) begin
                r_s1_a  <= bus.in_A;
                r_s1_b  <= bus.in_B;
                r_s1_op <= bus.in_Op;
                r_s1_r  <= bus.in_R;
                r_s1_z  <= bus.in_Zero;
            end

            if (bus.start) begin
                // Restart wins over stop and over any pending stage-1 sample.
                r_state    <= S_RUN;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
                r_error    <= 1'b0;
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
                r_ff_idx   <= '0;
                r_ff_op    <= '0;
                r_ff_exp   <= '0;
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (bus.stop) begin
                            r_state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                    default: begin
                    end
                endcase

                if (r_s1_vld) begin
                    if (w_match) begin
                        if (!(&r_pass_cnt)) begin
                            r_pass_cnt <= r_pass_cnt + 1'b1;
                        end
                    end else begin
                        if (!(&r_fail_cnt)) begin
                            r_fail_cnt <= r_fail_cnt + 1'b1;
                        end
                        if (!r_error) begin
                            r_error  <= 1'b1;
                            r_ff_idx <= w_idx;
                            r_ff_op  <= r_s1_op;
                            r_ff_exp <= w_exp_r;
                        end
                    end
                end
            end
        end
    end

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.error          = r_error;
    assign bus.pass_cnt       = r_pass_cnt;
    assign bus.fail_cnt       = r_fail_cnt;
    assign bus.first_fail_idx = r_ff_idx;
    assign bus.first_fail_op  = r_ff_op;
    assign bus.first_fail_exp = r_ff_exp;

endmodule
`default_nettype wire

// File: tb/tb_alu32_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu32_checker
// Description : Directed self-checking bench for alu32_checker. Drives inputs
//               on the falling edge and samples outputs on the falling edge,
//               away from the active rising edge. A second instance with a
//               4-bit counter width exercises counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu32_checker;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    alu32_checker_if #(.CNT_W(16)) bus  ();
    alu32_checker_if #(.CNT_W(4))  bus4 ();

    alu32_checker #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    alu32_checker #(.CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    // Directed vectors used for the back-to-back run (hand-computed results).
    localparam logic [31:0] VA  [8] = '{32'hFF00FF00, 32'h12340000, 32'h80000000, 32'hFFFF0000,
                                        32'h00000005, 32'h80000000, 32'h00000001, 32'h0F0F0F0F};
    localparam logic [31:0] VB  [8] = '{32'h0FF00FF0, 32'h00005678, 32'h80000000, 32'h0F0F0F0F,
                                        32'h00000007, 32'h00000004, 32'h00000024, 32'h30303030};
    localparam logic [2:0]  VOP [8] = '{3'b000, 3'b001, 3'b010, 3'b011,
                                        3'b100, 3'b101, 3'b110, 3'b111};
    localparam logic [31:0] VR  [8] = '{32'h0F000F00, 32'h12345678, 32'h00000000, 32'hF0F00F0F,
                                        32'hFFFFFFFE, 32'hF8000000, 32'h00000010, 32'hC0C0C0C0};
    localparam logic        VZ  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic        VO  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // One clock cycle of stimulus, applied at the falling edge.
    task automatic cyc(input logic st, input logic sp, input logic v,
                       input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] r, input logic z, input logic o);
        @(negedge clk);
        bus.start       = st;
        bus.stop        = sp;
        bus.in_valid    = v;
        bus.in_A        = a;
        bus.in_B        = b;
        bus.in_Op       = op;
        bus.in_R        = r;
        bus.in_Zero     = z;
        bus.in_Overflow = o;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_start();
        cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic smp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] r, input logic z, input logic o);
        cyc(1'b0, 1'b0, 1'b1, a, b, op, r, z, o);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.error !== 1'b0) $display("FAIL rst_error: got %b want 0", bus.error); else n_pass++;
        n_checks++; if (bus.pass_cnt !== 16'd0) $display("FAIL rst_pass: got %0d want 0", bus.pass_cnt); else n_pass++;
        n_checks++; if (bus.fail_cnt !== 16'd0) $display("FAIL rst_fail: got %0d want 0", bus.fail_cnt); else n_pass++;
        n_checks++; if (bus.first_fail_exp !== 32'd0) $display("FAIL rst_exp: got %h want 0", bus.first_fail_exp); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_idle_busy: got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_idle_ignore();
        smp(32'h0, 32'h0, 3'b000, 32'h0, 1'b1, 1'b0);
        smp(32'h1, 32'h1, 3'b000, 32'h5, 1'b0, 1'b0);
        idle(2);
        n_checks++; if (bus.pass_cnt !== 16'd0) $display("FAIL idle_pass: got %0d want 0", bus.pass_cnt); else n_pass++;
        n_checks++; if (bus.fail_cnt !== 16'd0) $display("FAIL idle_fail: got %0d want 0", bus.fail_cnt); else n_pass++;
        n_checks++; if (bus.error !== 1'b0) $display("FAIL idle_error: got %b want 0", bus.error); else n_pass++;
    endtask

    task automatic test_and();
        do_start();
        smp(32'hAAAAAAAA, 32'h55555555, 3'b000, 32'h0, 1'b1, 1'b0);
        idle(1);
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL and_busy: got %b want 1", bus.busy); else n_pass++;
        n_checks++; if (bus.pass_cnt !== 16'd0) $display("FAIL and_latency: got %0d want 0", bus.pass_cnt); else n_pass++;
        idle(1);
        n_checks++; if (bus.pass_cnt !== 16'd1) $display("FAIL and_pass: got %0d want 1", bus.pass_cnt); else n_pass++;
        n_checks++; if (bus.error !== 1'b0) $display("FAIL and_error: got %b want 0", bus.error); else n_pass++;
    endtask

    task automatic test_add_ovf();
        do_start();
        smp(32'h40000000, 32'h40000000, 3'b010, 32'h80000000, 1'b0, 1'b0);
        idle(2);
`ifdef ALU32_CHK_OVF_EN
        n_checks++; if (bus.fail_cnt !== 16'd1) $display("FAIL ovf_fail: got %0d want 1", bus.fail_cnt); else n_pass++;
        n_checks++; if (bus.error !== 1'b1) $display("FAIL ovf_error: got %b want 1", bus.error); else n_pass++;
        n_checks++; if (bus.first_fail_op !== 3'b010) $display("FAIL ovf_op: got %b want 010", bus.first_fail_op); else n_pass++;
        n_checks++; if (bus.first_fail_exp !== 32'h80000000) $display("FAIL ovf_exp: got %h want 80000000", bus.first_fail_exp); else n_pass++;
`else
        n_checks++; if (bus.pass_cnt !== 16'd1) $display("FAIL ovf_pass: got %0d want 1", bus.pass_cnt); else n_pass++;
        n_checks++; if (bus.error !== 1'b0) $display("FAIL ovf_error: got %b want 0", bus.error); else n_pass++;
`endif
    endtask

    task automatic test_sub_shift();
        do_start();
        smp(32'h00000020, 32'h80000019, 3'b100, 32'h80000007, 1'b0, 1'b1);
        smp(32'hAAAAAAAA, 32'd31,       3'b101, 32'hFFFFFFFF, 1'b0, 1'b0);
        smp(32'h54AAAAAA, 32'd31,       3'b110, 32'h00000000, 1'b1, 1'b0);
        idle(2);
        n_checks++; if (bus.pass_cnt !== 16'd3) $display("FAIL sub_sh_pass: got %0d want 3", bus.pass_cnt); else n_pass++;
        n_checks++; if (bus.error !== 1'b0) $display("FAIL sub_sh_error: got %b want 0", bus.error); else n_pass++;
        smp(32'hAAAAAAAA, 32'd31,       3'b101, 32'h7FFFFFFF, 1'b0, 1'b0);
        smp(32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'h00000000, 1'b1, 1'b0);
        idle(2);
        n_checks++; if (bus.fail_cnt !== 16'd2) $display("FAIL sra_fail: got %0d want 2", bus.fail_cnt); else n_pass++;
        n_checks++; if (bus.first_fail_idx !== 16'd3) $display("FAIL sra_idx: got %0d want 3", bus.first_fail_idx); else n_pass++;
        n_checks++; if (bus.first_fail_op !== 3'b101) $display("FAIL sra_op: got %b want 101", bus.first_fail_op); else n_pass++;
        n_checks++; if (bus.first_fail_exp !== 32'hFFFFFFFF) $display("FAIL sra_exp: got %h want ffffffff", bus.first_fail_exp); else n_pass++;
        n_checks++; if (bus.error !== 1'b1) $display("FAIL sra_error: got %b want 1", bus.error); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_start();
        for (int i = 0; i < 24; i++) begin
            cyc(1'b0, (i == 23), 1'b1, VA[i%8], VB[i%8], VOP[i%8], VR[i%8], VZ[i%8], VO[i%8]);
        end
        idle(1);
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL drain_busy: got %b want 1", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL drain_done: got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.pass_cnt !== 16'd23) $display("FAIL drain_pass: got %0d want 23", bus.pass_cnt); else n_pass++;
        idle(1);
        n_checks++; if (bus.done !== 1'b1) $display("FAIL done_done: got %b want 1", bus.done); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL done_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.pass_cnt !== 16'd24) $display("FAIL done_pass: got %0d want 24", bus.pass_cnt); else n_pass++;
        n_checks++; if (bus.fail_cnt !== 16'd0) $display("FAIL done_fail: got %0d want 0", bus.fail_cnt); else n_pass++;
        smp(32'h1, 32'h1, 3'b000, 32'h1, 1'b0, 1'b0);
        idle(2);
        n_checks++; if (bus.pass_cnt !== 16'd24) $display("FAIL done_ignore: got %0d want 24", bus.pass_cnt); else n_pass++;
    endtask

    task automatic test_start_stop();
        cyc(1'b1, 1'b1, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        idle(1);
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL ss_busy: got %b want 1", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL ss_done: got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.pass_cnt !== 16'd0) $display("FAIL ss_clear: got %0d want 0", bus.pass_cnt); else n_pass++;
        idle(2);
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL ss_stay_run: got %b want 1", bus.busy); else n_pass++;
    endtask

    task automatic test_saturation();
        @(negedge clk);
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start    = 1'b0;
        bus4.in_valid = 1'b1;
        bus4.in_Op    = 3'b000;
        bus4.in_A     = 32'h0;
        bus4.in_B     = 32'h0;
        bus4.in_R     = 32'h0;
        bus4.in_Zero  = 1'b1;
        for (int i = 1; i < 20; i++) @(negedge clk);
        bus4.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus4.pass_cnt !== 4'd15) $display("FAIL sat_pass: got %0d want 15", bus4.pass_cnt); else n_pass++;
        n_checks++; if (bus4.fail_cnt !== 4'd0) $display("FAIL sat_fail0: got %0d want 0", bus4.fail_cnt); else n_pass++;
        bus4.in_valid = 1'b1;
        bus4.in_R     = 32'h1;
        bus4.in_Zero  = 1'b0;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus4.fail_cnt !== 4'd1) $display("FAIL sat_fail1: got %0d want 1", bus4.fail_cnt); else n_pass++;
        n_checks++; if (bus4.first_fail_idx !== 4'd15) $display("FAIL sat_idx: got %0d want 15", bus4.first_fail_idx); else n_pass++;
        n_checks++; if (bus4.pass_cnt !== 4'd15) $display("FAIL sat_hold: got %0d want 15", bus4.pass_cnt); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        do_start();
        smp(32'h1, 32'h2, 3'b001, 32'h0, 1'b1, 1'b0);
        smp(32'h1, 32'h2, 3'b001, 32'h3, 1'b0, 1'b0);
        idle(2);
        n_checks++; if (bus.pass_cnt !== 16'd1) $display("FAIL mid_pre_pass: got %0d want 1", bus.pass_cnt); else n_pass++;
        n_checks++; if (bus.error !== 1'b1) $display("FAIL mid_pre_error: got %b want 1", bus.error); else n_pass++;
        smp(32'h1, 32'h2, 3'b001, 32'h3, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        #1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.error !== 1'b0) $display("FAIL mid_error: got %b want 0", bus.error); else n_pass++;
        n_checks++; if (bus.pass_cnt !== 16'd0) $display("FAIL mid_pass: got %0d want 0", bus.pass_cnt); else n_pass++;
        n_checks++; if (bus.fail_cnt !== 16'd0) $display("FAIL mid_fail: got %0d want 0", bus.fail_cnt); else n_pass++;
        n_checks++; if (bus.first_fail_op !== 3'b000) $display("FAIL mid_op: got %b want 000", bus.first_fail_op); else n_pass++;
        n_checks++; if (bus.first_fail_exp !== 32'd0) $display("FAIL mid_exp: got %h want 0", bus.first_fail_exp); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        smp(32'h1, 32'h2, 3'b001, 32'h3, 1'b0, 1'b0);
        idle(2);
        n_checks++; if (bus.pass_cnt !== 16'd0) $display("FAIL mid_lost: got %0d want 0", bus.pass_cnt); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL mid_idle: got %b want 0", bus.busy); else n_pass++;
    endtask

    initial begin
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_A         = '0;
        bus.in_B         = '0;
        bus.in_Op        = '0;
        bus.in_R         = '0;
        bus.in_Zero      = 1'b0;
        bus.in_Overflow  = 1'b0;
        bus4.start       = 1'b0;
        bus4.stop        = 1'b0;
        bus4.in_valid    = 1'b0;
        bus4.in_A        = '0;
        bus4.in_B        = '0;
        bus4.in_Op       = '0;
        bus4.in_R        = '0;
        bus4.in_Zero     = 1'b0;
        bus4.in_Overflow = 1'b0;

        test_reset();
        test_idle_ignore();
        test_and();
        test_add_ovf();
        test_sub_shift();
        test_back_to_back();
        test_start_stop();
        test_saturation();
        test_reset_midrun();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
